block_lookup: RTL
=================

BLOCK_LOOKUP -- requirements
Module: block_lookup

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of SRAM block slots (power of two, >=2).
REQ-002 SHALL have parameter TAG_W, default 21, width of the requested block number.
REQ-003 SHALL have parameter IDX_W, default $clog2(NUM_SLOTS), width of the slot index.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 req_addr_i  in  TAG_W  block number of the current in-window request.
REQ-007 valid_i  in  1  an in-window request is present this cycle.
REQ-008 sram_addr_idx_o  out  IDX_W  slot holding req_addr_i on hit, else 0.
REQ-009 block_o  out  1  stall the request path (request zeroed, grant suppressed).
REQ-010 flush_i  in  1  single-cycle pulse; invalidate all table entries.
REQ-011 swap_req_o  out  1  request to the swap engine to load a block into a slot.
REQ-012 swap_gnt_i  in  1  swap engine accepts swap_req_o this cycle.
REQ-013 swap_tag_o  out  TAG_W  block number to load.
REQ-014 swap_slot_o  out  IDX_W  destination slot.
REQ-015 swap_evict_valid_o  out  1  destination slot held a valid block.
REQ-016 swap_evict_tag_o  out  TAG_W  tag being evicted (0 when evict_valid is 0).
REQ-017 swap_done_i  in  1  single-cycle pulse; load into the slot complete.
REQ-018 miss_cnt_o  out  16  saturating count of misses accepted.

Function
REQ-019 Table: NUM_SLOTS entries of {valid, tag}; hit = valid_i and some valid entry tag equals req_addr_i.
REQ-020 Lookup is combinational: sram_addr_idx_o = matching slot in the same cycle; on multiple matches the lowest index wins.
REQ-021 block_o = (state != IDLE) or (valid_i and not hit), combinational, zero-cycle.
REQ-022 FSM states: IDLE, REQ, WAIT, UPDATE.
REQ-023 IDLE: on valid_i and miss, latch tag and victim slot, increment miss_cnt_o (saturate at 0xFFFF), go to REQ.
REQ-024 Victim: lowest-index invalid slot if any exists, else slot rr_ptr.
REQ-025 rr_ptr (IDX_W bits, reset 0) increments modulo NUM_SLOTS only when a valid entry is chosen as victim.
REQ-026 REQ: swap_req_o = 1 with swap_tag_o/swap_slot_o/evict outputs stable; on swap_gnt_i go to WAIT.
REQ-027 swap_req_o SHALL stay high and its payload unchanged until swap_gnt_i is sampled high.
REQ-028 Victim entry valid bit is cleared when leaving REQ so a flush or lookup never reports the slot mid-load.
REQ-029 WAIT: on swap_done_i go to UPDATE; swap_done_i outside WAIT is ignored.
REQ-030 UPDATE: write {1, latched tag} to the victim slot; go to IDLE next cycle; the retried request then hits.
REQ-031 Miss-to-hit latency with gnt and done immediate: 4 cycles of block_o high (IDLE-miss, REQ, WAIT, UPDATE).
REQ-032 flush_i in IDLE, REQ or WAIT clears all valid bits; in REQ/WAIT the in-flight load still completes and writes its entry.
REQ-033 flush_i in UPDATE clears all valid bits including the entry written that cycle (flush wins).
REQ-034 flush_i and a miss in the same IDLE cycle: flush applies, victim is chosen from the pre-flush table.
REQ-035 valid_i low: no state change in IDLE, block_o = 0 in IDLE.
REQ-036 swap outputs not in REQ: swap_req_o = 0; payload outputs SHALL hold the latched values.

Reset
REQ-037 rst_i high SHALL, at the next edge, clear all valid bits and tags, rr_ptr = 0, miss_cnt_o = 0, state = IDLE, latched tag/slot = 0.
REQ-038 Reset mid-operation (REQ/WAIT/UPDATE) SHALL abandon the swap with no table write; swap_req_o = 0 from the following cycle.
REQ-039 Outputs while in reset: block_o per REQ-021 with an empty table, swap_req_o = 0, sram_addr_idx_o = 0.

Verification
REQ-040 Cold miss: after reset, valid_i=1, req_addr_i=0x00012, gnt and done one cycle later -> swap_slot_o=0, evict_valid=0, block_o high 4 cycles, then hit with idx 0, miss_cnt_o=1.
REQ-041 Fill and evict: load tags 0x10..0x13 into slots 0..3, then miss 0x14 -> swap_slot_o=0, evict_valid=1, evict_tag=0x10, rr_ptr=1; next miss 0x15 evicts slot 1 (0x11).
REQ-042 Gnt stall: hold swap_gnt_i low 5 cycles -> swap_req_o and payload constant, block_o high throughout.
REQ-043 Flush in WAIT: slots hold 0x10..0x13, miss 0x20 into slot 0, flush_i in WAIT -> after UPDATE only slot 0 valid (tag 0x20), request 0x11 misses into slot 1.
REQ-044 Reset mid-WAIT: rst_i during WAIT, then swap_done_i pulse -> no table write, table empty, request 0x20 misses again.
REQ-045 Counter saturation: force 0x10000 misses -> miss_cnt_o stays 0xFFFF.

Source files
------------

// File: rtl/block_lookup.sv
// Block lookup table: maps a requested block number to one of NUM_SLOTS SRAM
// slots and, on a miss, drives a swap engine to load the block into a victim slot.
module block_lookup #(
  parameter int NUM_SLOTS = 4,
  parameter int TAG_W     = 21,
  parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [TAG_W-1:0] req_addr_i,
  input  logic             valid_i,
  output logic [IDX_W-1:0] sram_addr_idx_o,
  output logic             block_o,
  input  logic             flush_i,
  output logic             swap_req_o,
  input  logic             swap_gnt_i,
  output logic [TAG_W-1:0] swap_tag_o,
  output logic [IDX_W-1:0] swap_slot_o,
  output logic             swap_evict_valid_o,
  output logic [TAG_W-1:0] swap_evict_tag_o,
  input  logic             swap_done_i,
  output logic [15:0]      miss_cnt_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q [NUM_SLOTS];
  logic [TAG_W-1:0]     tag_d [NUM_SLOTS];
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [15:0]          miss_cnt_q, miss_cnt_d;
  logic [TAG_W-1:0]     lat_tag_q, lat_tag_d;
  logic [IDX_W-1:0]     lat_slot_q, lat_slot_d;
  logic                 evict_valid_q, evict_valid_d;
  logic [TAG_W-1:0]     evict_tag_q, evict_tag_d;

  logic                 hit;
  logic [IDX_W-1:0]     hit_idx;
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;
  logic [IDX_W-1:0]     victim;

  // Descending scans so the lowest matching / lowest free index is the one kept.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (valid_i && !rst_i && valid_q[i] && (tag_q[i] == req_addr_i)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    victim = free_found ? free_idx : rr_ptr_q;
  end

  assign sram_addr_idx_o    = hit ? hit_idx : '0;
  assign block_o            = (state_q != S_IDLE) || (valid_i && !hit);
  assign swap_req_o         = (state_q == S_REQ) && !rst_i;
  assign swap_tag_o         = lat_tag_q;
  assign swap_slot_o        = lat_slot_q;
  assign swap_evict_valid_o = evict_valid_q;
  assign swap_evict_tag_o   = evict_tag_q;
  assign miss_cnt_o         = miss_cnt_q;

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    tag_d         = tag_q;
    rr_ptr_d      = rr_ptr_q;
    miss_cnt_d    = miss_cnt_q;
    lat_tag_d     = lat_tag_q;
    lat_slot_d    = lat_slot_q;
    evict_valid_d = evict_valid_q;
    evict_tag_d   = evict_tag_q;

    case (state_q)
      S_IDLE: begin
        if (valid_i && !hit) begin
          state_d       = S_REQ;
          lat_tag_d     = req_addr_i;
          lat_slot_d    = victim;
          evict_valid_d = !free_found;
          evict_tag_d   = free_found ? '0 : tag_q[victim];
          if (!free_found) rr_ptr_d = rr_ptr_q + IDX_W'(1);
          if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
        end
      end
      S_REQ: begin
        // The slot goes invalid as the load starts so nothing can hit a half-loaded slot.
        if (swap_gnt_i) begin
          state_d             = S_WAIT;
          valid_d[lat_slot_q] = 1'b0;
        end
      end
      S_WAIT: begin
        if (swap_done_i) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        valid_d[lat_slot_q] = 1'b1;
        tag_d[lat_slot_q]   = lat_tag_q;
        state_d             = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Applied last so a flush overrides the UPDATE write in the same cycle.
    if (flush_i) valid_d = '0;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      state_q       <= S_IDLE;
      valid_q       <= '0;
      rr_ptr_q      <= '0;
      miss_cnt_q    <= '0;
      lat_tag_q     <= '0;
      lat_slot_q    <= '0;
      evict_valid_q <= 1'b0;
      evict_tag_q   <= '0;
      // NOTE: the tag array is small flop storage and is cleared on reset; an SRAM-backed table would not be.
      for (int i = 0; i < NUM_SLOTS; i++) tag_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      rr_ptr_q      <= rr_ptr_d;
      miss_cnt_q    <= miss_cnt_d;
      lat_tag_q     <= lat_tag_d;
      lat_slot_q    <= lat_slot_d;
      evict_valid_q <= evict_valid_d;
      evict_tag_q   <= evict_tag_d;
      for (int i = 0; i < NUM_SLOTS; i++) tag_q[i] <= tag_d[i];
    end
  end

endmodule
